// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// shift_pkg : shared encodings for the shift sequence controller
// Revision  : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Shift-register mode codes presented on sr_s
  localparam logic [2:0] c_sr_hold = 3'b000;
  localparam logic [2:0] c_sr_load = 3'b001;
  localparam logic [2:0] c_sr_shl  = 3'b010;
  localparam logic [2:0] c_sr_shr  = 3'b011;

  // Fill modes; 2'b11 is deliberately left to fall through as logical
  localparam logic [1:0] c_op_logical = 2'b00;
  localparam logic [1:0] c_op_rotate  = 2'b01;
  localparam logic [1:0] c_op_arith   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// shift_seq_ctrl_if : request/response and shift-register signals
// Revision          : 1.0 - initial release
// ============================================================================
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amt;
  logic             dir;
  logic [1:0]       op;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_data;
  logic [2:0]       sr_s;
  logic             sr_sl;
  logic             sr_sr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, data_in, amt, dir, op, sr_q,
    input  sr_data, sr_s, sr_sl, sr_sr, busy, done, result
  );

  modport slave (
    input  start, data_in, amt, dir, op, sr_q,
    output sr_data, sr_s, sr_sl, sr_sr, busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/shift_fill_sel.sv
`default_nettype none
// ============================================================================
// shift_fill_sel : serial fill bit for the external shift register
// Revision       : 1.0 - initial release
// ============================================================================
module shift_fill_sel
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic [1:0]       op,
  input  wire logic             dir,
  input  wire logic [WIDTH-1:0] sr_q,
  output logic                  sl,
  output logic                  sr
);
  // Only the end bits feed the fill; the rest are tied off here
  logic w_unused;
  assign w_unused = ^sr_q[WIDTH-2:1];

  always_comb begin
    sl = 1'b0;
    sr = 1'b0;
    if (!dir) begin
      if (op == c_op_rotate) sl = sr_q[WIDTH-1];
    end else begin
      case (op)
        c_op_rotate: sr = sr_q[0];
        c_op_arith:  sr = sr_q[WIDTH-1];
        default:     sr = 1'b0;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
// shift_seq_ctrl : sequences load/shift/hold on an external shift register
// Revision       : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input wire logic        clk,
  input wire logic        rst_n,
  shift_seq_ctrl_if.slave bus
);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_result;
  logic [AMT_W-1:0] r_cnt;
  logic             r_dir;
  logic [1:0]       r_op;
  logic             r_done;

  logic [2:0]       w_sr_s;
  logic [WIDTH-1:0] w_sr_data;
  logic             w_fill_sl, w_fill_sr;

  shift_fill_sel #(.WIDTH(WIDTH)) u_fill (
    .op   (r_op),
    .dir  (r_dir),
    .sr_q (bus.sr_q),
    .sl   (w_fill_sl),
    .sr   (w_fill_sr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_op     <= 2'b00;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      if (r_state == S_IDLE && bus.start) begin
        r_data <= bus.data_in;
        r_cnt  <= bus.amt;
        r_dir  <= bus.dir;
        r_op   <= bus.op;
      end
      if (r_state == S_SHIFT) r_cnt <= r_cnt - AMT_W'(1);
      // sr_q is settled here because DONE holds the register
      if (r_state == S_DONE) r_result <= bus.sr_q;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_sr_s    = c_sr_hold;
    w_sr_data = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_sr_s    = c_sr_load;
        w_sr_data = r_data;
        w_next    = (r_cnt == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        w_sr_s = r_dir ? c_sr_shr : c_sr_shl;
        if (r_cnt == AMT_W'(1)) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.sr_s    = w_sr_s;
  assign bus.sr_data = w_sr_data;
  assign bus.sr_sl   = (r_state == S_SHIFT) ? w_fill_sl : 1'b0;
  assign bus.sr_sr   = (r_state == S_SHIFT) ? w_fill_sr : 1'b0;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.result  = r_result;
endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, data width of the operand and of the downstream parallel-load shift register.
REQ-002 Parameter: AMT_W, 3, width of the shift-amount field.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  request, sampled only in IDLE.
REQ-007 Port: data_in  input  WIDTH  operand.
REQ-008 Port: amt  input  AMT_W  shift count, 0..7.
REQ-009 Port: dir  input  1  direction: 0 = left, 1 = right.
REQ-010 Port: op  input  2  fill mode: 00 logical, 01 rotate, 10 arithmetic, 11 treated as logical.
REQ-011 Port: sr_q  input  WIDTH  current parallel output of the shift register.
REQ-012 Port: sr_data  output  WIDTH  parallel-load value for the shift register.
REQ-013 Port: sr_s  output  3  register mode: 000 hold, 001 load, 010 shift left, 011 shift right.
REQ-014 Port: sr_sl  output  1  serial bit entering bit 0 on a left shift.
REQ-015 Port: sr_sr  output  1  serial bit entering bit WIDTH-1 on a right shift.
REQ-016 Port: busy  output  1  high while an operation is in progress.
REQ-017 Port: done  output  1  one-cycle completion pulse.
REQ-018 Port: result  output  WIDTH  registered final value.

Function
REQ-019 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-020 Transition IDLE->LOAD SHALL occur when start=1; data_in, amt, dir and op SHALL be captured on that edge.
REQ-021 LOAD SHALL drive sr_s=001 and sr_data=captured operand for exactly one cycle.
- If amt=0, LOAD SHALL go to DONE.
- Otherwise LOAD SHALL go to SHIFT.
REQ-022 SHIFT SHALL drive sr_s=010 (dir=0) or 011 (dir=1) for exactly amt cycles, then go to DONE; a down-counter SHALL track the remaining shifts.
REQ-023 Left fill (sr_sl) SHALL be:
- logical: 0;
- rotate: sr_q[WIDTH-1];
- arithmetic: 0.
REQ-024 Right fill (sr_sr) SHALL be:
- logical: 0;
- rotate: sr_q[0];
- arithmetic: sr_q[WIDTH-1].
REQ-025 The serial port not used in the current cycle SHALL be driven to 0.
REQ-026 DONE SHALL drive sr_s=000 and SHALL last one cycle, then go to IDLE.
- result SHALL be loaded from sr_q on the DONE exit edge.
- done SHALL be asserted for the single following cycle.
REQ-027 IDLE SHALL drive sr_s=000, sr_data=0, sr_sl=0 and sr_sr=0.
REQ-028 busy SHALL be 1 exactly in LOAD, SHIFT and DONE.
REQ-029 Latency: done SHALL be high amt+3 cycles after the edge on which start was sampled.
REQ-030 start asserted while busy=1 SHALL be ignored and SHALL not be queued.
REQ-031 A start in the same cycle that done=1 SHALL be accepted, giving back-to-back operation.
REQ-032 result SHALL hold its value until the next completion.

Reset
REQ-033 rst_n=0 SHALL force IDLE asynchronously, including in the middle of an operation.
REQ-034 On reset, result, done, busy, the shift counter and the captured fields SHALL all be 0.
REQ-035 No done pulse SHALL be produced for an operation aborted by reset.

Structure
REQ-036 A shared package shift_pkg SHALL hold:
- the sr_s mode constants (HOLD, LOAD, SHL, SHR);
- the op encodings;
- the FSM state enum.
REQ-037 The fill-bit selection SHALL be a combinational sub-module, shift_fill_sel (inputs op, dir, sr_q; outputs sl, sr).
REQ-038 The shift register SHALL remain external; the block SHALL contain no datapath shifter.

Verification
REQ-039 The bench SHALL connect a WIDTH=8 register honouring the sr_s codes, and SHALL cover the following scenarios.
REQ-040 data_in=0x3A, amt=2, dir=0, op=00 -> result=0xE8, done high 5 cycles after start.
REQ-041 data_in=0x3A, amt=3, dir=1, op=01 -> result=0x47, done high 6 cycles after start.
REQ-042 data_in=0x96, amt=2, dir=1, op=10 -> result=0xE5, and sr_sr=1 during both SHIFT cycles.
REQ-043 data_in=0x3A, amt=0 -> no SHIFT cycles, result=0x3A, done high 3 cycles after start.
REQ-044 Second start pulsed while busy -> ignored, and only one done pulse is seen.
REQ-045 rst_n=0 during SHIFT -> busy=0, result=0 and sr_s=000 immediately, with no done pulse.
REQ-046 A new operation after reset SHALL complete correctly.
